// File: rtl/tile_map_ctrl.sv
// Tile-map storage controller: display read port, nibble writes and bulk fill engine.
// Define TILE_MAP_DOUBLE_BUFFER_EN for front/back banks with frame-synchronous swap.
module tile_map_ctrl #(
  parameter int unsigned N_WORDS = 256,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vde,
  input  logic [ADDR_W-1:0] current_tile,
  output logic [31:0]       sprite_addr,
  input  logic              frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_nib,
  input  logic [3:0]        wr_sprite,
  input  logic              fill_start,
  input  logic [3:0]        fill_val,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              swap_req,
  output logic              swap_done
);

`ifdef TILE_MAP_DOUBLE_BUFFER_EN
  localparam int unsigned N_BANKS = 2;
`else
  localparam int unsigned N_BANKS = 1;
`endif

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_ptr;
  logic [3:0]        fill_val_q;
  logic              fill_last_c;
  logic              fill_we;
  logic              wr_we;
  logic              front_sel;
  logic              back_sel;
  logic [31:0]       mem [N_BANKS][N_WORDS];

  // Display owns the port while vde is high; fill outranks external writes.
  assign wr_ready = ~rst & ~vde & (state == IDLE) & ~fill_start;
  assign wr_we    = wr_valid & wr_ready;
  assign fill_we  = ~rst & ~vde & (state == FILL);

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    fill_last_c = 1'b0;
    unique case (state)
      IDLE: if (fill_start) state_nxt = FILL;
      FILL: begin
        if (fill_we && (fill_ptr == ADDR_W'(N_WORDS - 1))) begin
          state_nxt   = IDLE;
          fill_last_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers and display read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_ptr    <= '0;
      fill_val_q  <= '0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
      sprite_addr <= '0;
    end else begin
      state     <= state_nxt;
      fill_busy <= (state_nxt == FILL);
      fill_done <= fill_last_c;
      if (state == IDLE && fill_start) begin
        fill_ptr   <= '0;
        fill_val_q <= fill_val;
      end else if (fill_we && !fill_last_c) begin
        fill_ptr <= fill_ptr + ADDR_W'(1);
      end
      if (vde) sprite_addr <= mem[front_sel][current_tile];
    end
  end

  // Storage writes; contents survive reset
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[back_sel][fill_ptr] <= {8{fill_val_q}};
    end else if (wr_we) begin
      mem[back_sel][wr_addr][{wr_nib, 2'b00} +: 4] <= wr_sprite;
    end
  end

`ifdef TILE_MAP_DOUBLE_BUFFER_EN
  logic bank_sel;
  logic swap_pend;
  logic swap_take_c;

  // A pending swap only lands on a frame boundary while no fill is running
  assign swap_take_c = frame_start & swap_pend & (state == IDLE);
  assign front_sel   = bank_sel;
  assign back_sel    = ~bank_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel  <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_take_c;
      if (swap_take_c) bank_sel <= ~bank_sel;
      if (swap_req) swap_pend <= 1'b1;
      else if (swap_take_c) swap_pend <= 1'b0;
    end
  end
`else
  logic unused_swap;

  assign front_sel   = 1'b0;
  assign back_sel    = 1'b0;
  assign swap_done   = 1'b0;
  assign unused_swap = ^{swap_req, frame_start};
`endif

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Directed bench for tile_map_ctrl with a per-cycle behavioural reference model.
module tb_tile_map_ctrl;

`ifdef TILE_MAP_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vde;
  logic [7:0]  current_tile;
  logic [31:0] sprite_addr;
  logic        frame_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [2:0]  wr_nib;
  logic [3:0]  wr_sprite;
  logic        fill_start;
  logic [3:0]  fill_val;
  logic        fill_busy;
  logic        fill_done;
  logic        swap_req;
  logic        swap_done;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  tile_map_ctrl dut (
    .clk(clk), .rst(rst), .vde(vde), .current_tile(current_tile),
    .sprite_addr(sprite_addr), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_nib(wr_nib), .wr_sprite(wr_sprite), .fill_start(fill_start),
    .fill_val(fill_val), .fill_busy(fill_busy), .fill_done(fill_done),
    .swap_req(swap_req), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  // Reference model: two word arrays, a fill progress counter and a bank selector
  logic [31:0] mm [2][256];
  logic [31:0] e_sa;
  bit          m_busy, m_pend, e_fd, e_sd;
  int          m_idx, m_sel;
  logic [3:0]  m_fv;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mm[b][i] = 'x;
    e_sa = 'x; m_busy = 0; m_pend = 0; e_fd = 0; e_sd = 0; m_idx = 0; m_sel = 0; m_fv = 0;
  end

  always @(posedge clk) begin
    int  fb, bb;
    bit  was_busy, take;
    fb = m_sel;
    bb = DB ? 1 - m_sel : 0;
    if (rst) begin
      m_busy = 0; m_idx = 0; e_sa = 0; e_fd = 0; e_sd = 0; m_pend = 0; m_sel = 0;
    end else begin
      was_busy = m_busy;
      e_fd = 0;
      if (vde) e_sa = mm[fb][current_tile];
      if (m_busy) begin
        if (!vde) begin
          mm[bb][m_idx] = {8{m_fv}};
          if (m_idx == 255) begin m_busy = 0; e_fd = 1; end
          else m_idx++;
        end
      end else if (fill_start) begin
        m_busy = 1; m_idx = 0; m_fv = fill_val;
      end else if (wr_valid && !vde) begin
        mm[bb][wr_addr][wr_nib*4 +: 4] = wr_sprite;
      end
      take = DB && frame_start && m_pend && !was_busy;
      e_sd = take;
      if (take) m_sel = 1 - m_sel;
      if (DB && swap_req) m_pend = 1;
      else if (take) m_pend = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      if (^e_sa !== 1'bx) chk("sprite_addr", sprite_addr, e_sa);
      chk("wr_ready", 32'(wr_ready), 32'(!rst && !vde && !m_busy && !fill_start));
      chk("fill_busy", 32'(fill_busy), 32'(m_busy));
      chk("fill_done", 32'(fill_done), 32'(e_fd));
      chk("swap_done", 32'(swap_done), 32'(e_sd));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [2:0] n, input logic [3:0] s);
    wr_addr = a; wr_nib = n; wr_sprite = s; wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic fill(input logic [3:0] v);
    fill_val = v; fill_start = 1'b1;
    step(1);
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      step(1);
      if (fill_done) seen = 1;
    end
    chk("fill_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic swap();
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    frame_start = 1'b1; step(1); frame_start = 1'b0;
    step(1);
  endtask

  task automatic rd(input logic [7:0] t);
    vde = 1'b1; current_tile = t;
    step(1);
  endtask

  initial begin
    int nd;
    rst = 1'b1; vde = 1'b0; current_tile = '0; frame_start = 0; wr_valid = 0;
    wr_addr = '0; wr_nib = '0; wr_sprite = '0; fill_start = 0; fill_val = '0; swap_req = 0;
    step(1);
    checking = 1'b1;
    step(1);
    chk("rst_sprite_addr", sprite_addr, 32'h0);
    chk("rst_fill_busy", 32'(fill_busy), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;

    // Zero fill colliding with a write request: fill wins
    wr_valid = 1'b1; wr_addr = 8'd9; wr_nib = 3'd0; wr_sprite = 4'hF;
    fill_val = 4'h0; fill_start = 1'b1;
    #1 chk("wr_ready_vs_fill", 32'(wr_ready), 32'd0);
    step(1);
    fill_start = 1'b0; wr_valid = 1'b0;
    wait_done(600);
    if (DB) begin swap(); fill(4'h0); wait_done(600); end

    // Read before and after loading word 5
    rd(8'd5);
    chk("word5_blank", sprite_addr, 32'h0);
    vde = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] pat;
      pat = 32'h12345678;
      wr(8'd5, 3'(k), pat[4*k +: 4]);
    end
    if (DB) swap();
    rd(8'd5);
    chk("word5_loaded", sprite_addr, 32'h12345678);

    // Single-nibble write, then blocked writes while display is active
    vde = 1'b0;
    wr(8'd3, 3'd2, 4'hA);
    if (DB) swap();
    rd(8'd3);
`ifndef TILE_MAP_DOUBLE_BUFFER_EN
    chk("word3_nib2", sprite_addr, 32'h00000A00);
`endif
    wr_addr = 8'd3; wr_nib = 3'd0; wr_sprite = 4'h5; wr_valid = 1'b1;
    chk("wr_ready_vde", 32'(wr_ready), 32'd0);
    step(2);
    wr_valid = 1'b0;
`ifndef TILE_MAP_DOUBLE_BUFFER_EN
    chk("word3_kept", sprite_addr, 32'h00000A00);
`endif

    // Fill 7 while display toggles 100 on / 100 off
    vde = 1'b0;
    fill(4'h7);
    nd = 0;
    for (int c = 0; c < 700; c++) begin
      vde = ((c / 100) % 2) == 1;
      step(1);
      if (fill_done) nd++;
    end
    chk("fill_done_count", 32'(nd), 32'd1);
    if (DB) begin vde = 1'b0; swap(); end
    for (int i = 0; i < 256; i++) rd(8'(i));
    rd(8'd200);
    chk("word200_fill7", sprite_addr, 32'h77777777);

    // Reset after 40 fill writes aborts the fill
    vde = 1'b0;
    fill(4'h3);
    step(40);
    rst = 1'b1;
    step(1);
    chk("abort_fill_busy", 32'(fill_busy), 32'd0);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 300; c++) begin
      step(1);
      if (fill_done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
`ifndef TILE_MAP_DOUBLE_BUFFER_EN
    rd(8'd39);
    chk("word39_refilled", sprite_addr, 32'h33333333);
    rd(8'd40);
    chk("word40_old", sprite_addr, 32'h77777777);

    // Swap requests have no effect on the single-bank build
    vde = 1'b0;
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    frame_start = 1'b1; step(1); frame_start = 1'b0;
    chk("no_swap_done", 32'(swap_done), 32'd0);
    step(1);
    chk("no_swap_done_late", 32'(swap_done), 32'd0);
    rd(8'd5);
    chk("word5_after_swap", sprite_addr, 32'h33333333);
`else
    // Back-bank write becomes visible only after the frame-boundary swap
    vde = 1'b0;
    fill(4'h0); wait_done(600);
    swap();
    fill(4'h0); wait_done(600);
    wr(8'd0, 3'd0, 4'hB);
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    rd(8'd0);
    chk("pre_swap_word0", sprite_addr, 32'h0);
    vde = 1'b0; frame_start = 1'b1; step(1); frame_start = 1'b0;
    chk("swap_done_pulse", 32'(swap_done), 32'd1);
    step(1);
    chk("swap_done_once", 32'(swap_done), 32'd0);
    rd(8'd0);
    chk("post_swap_word0", sprite_addr, 32'h0000000B);
`endif

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_map_ctrl.md
TILE_MAP_CTRL -- requirements
Module: tile_map_ctrl

Interface
REQ-001 Parameter N_WORDS, default 256: number of 32-bit tile-map words, each packing 8 tiles of 4-bit sprite index, tile k in bits [4k+3:4k].
REQ-002 Parameter ADDR_W, default 8: word address width; N_WORDS = 2**ADDR_W.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 vde  input  1: display active-video flag; high = display owns the storage port.
REQ-006 current_tile  input  ADDR_W: word index requested by the pixel generator.
REQ-007 sprite_addr  output  32: registered tile-map word for the pixel generator.
REQ-008 frame_start  input  1: one-cycle pulse at start of vertical blank.
REQ-009 wr_valid  input  1; wr_ready  output  1: write handshake; transfer when both high on a clock edge.
REQ-010 wr_addr  input  ADDR_W; wr_nib  input  3; wr_sprite  input  4: target word, tile slot, new sprite index.
REQ-011 fill_start  input  1; fill_val  input  4: pulse to overwrite every tile with fill_val.
REQ-012 fill_busy  output  1; fill_done  output  1: fill in progress; one-cycle completion pulse.
REQ-013 swap_req  input  1; swap_done  output  1: request a bank swap; one-cycle pulse when the swap takes effect.

Function
REQ-014 Read path: when vde=1, sprite_addr <= front_bank[current_tile] each cycle (latency 1); when vde=0, sprite_addr holds its value.
REQ-015 Storage port arbitration, fixed priority: display (vde=1) > fill engine > external write.
REQ-016 wr_ready = ~rst & ~vde & (state==IDLE) & ~fill_start; combinational.
REQ-017 An accepted write replaces only nibble wr_nib of back_bank[wr_addr]; the other 28 bits are unchanged; the write is visible on the read path one cycle later (single-bank build).
REQ-018 FSM states IDLE, FILL; IDLE->FILL on fill_start in IDLE; fill_start in FILL is ignored.
REQ-019 FILL: on each cycle with vde=0, write {8{fill_val latched at start}} to back_bank[fill_ptr] and increment fill_ptr from 0; stall without advancing while vde=1.
REQ-020 FILL->IDLE after writing word N_WORDS-1; fill_done pulses on the cycle after that write; fill_busy = (state==FILL).
REQ-021 fill_start and wr_valid in the same IDLE cycle: fill wins and the write is not accepted (wr_ready=0).
REQ-022 fill_ptr and all address arithmetic are ADDR_W bits wide; no wrap occurs because FILL ends at N_WORDS-1.

Reset
REQ-023 rst: state=IDLE, fill_ptr=0, sprite_addr=0, fill_busy=0, fill_done=0, swap_done=0, swap pending=0, bank_sel=0.
REQ-024 Reset asserted mid-fill aborts the fill with no fill_done pulse; partially filled words keep their new values.
REQ-025 Tile-map storage contents are not reset.

Configuration
REQ-026 Macro TILE_MAP_DOUBLE_BUFFER_EN defined: two banks; the front bank is read by the display, and the back bank receives all writes and fills.
REQ-027 With the macro defined, swap_req sets a pending flag; on frame_start with pending=1 and state=IDLE, bank_sel toggles, pending clears, and swap_done pulses the next cycle; a swap that arrives during FILL waits for the next frame_start after IDLE is reached.
REQ-028 Macro undefined: one bank serves as both front and back; swap_req is ignored, swap_done is tied to 0, and the pending logic is absent.

Verification
REQ-029 After rst, vde=1, current_tile=5 -> sprite_addr=0x00000000 until written; preload word 5=0x12345678 -> sprite_addr=0x12345678 one cycle later.
REQ-030 vde=0, write addr=3, nib=2, sprite=0xA to word 0x00000000 -> word 3 reads 0x00000A00; wr_ready=0 whenever vde=1.
REQ-031 fill_start, fill_val=0x7, vde toggling 100 on/100 off -> every word = 0x77777777; fill_busy high throughout; exactly one fill_done after 256 vde=0 write cycles.
REQ-032 fill_start and wr_valid in the same cycle -> no write handshake; fill completes; a rst at fill_ptr=40 -> fill_busy=0, no fill_done, words 0..39 filled.
REQ-033 Macro defined: write 0xB to word 0 nib 0, swap_req, then frame_start -> sprite_addr unchanged before frame_start, 0x0000000B after it, and swap_done pulses once.
REQ-034 Macro undefined: swap_req plus frame_start -> swap_done stays 0 and reads are unaffected.
